// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types for the pipeline hazard controller.
// Holds the opcode and register-index types, the FSM state type, the
// shadow-slot record and the operand-usage helpers.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // The decoder marks an unused register field with REG_UNKNOWN. It shares
    // x0's encoding, so either value means "no dependency".
    localparam reg_addr_t REG_UNKNOWN = '0;

    typedef enum logic [3:0] {
        LUI,
        AUIPC,
        JAL,
        JALR,
        BRANCH,
        LOAD,
        STORE,
        ARITHMETIC_IMM,
        ARITHMETIC_REG,
        SYSTEM
    } opcode_t;

    typedef enum logic [1:0] {
        RUN,
        RAW_STALL,
        MEM_WAIT
    } hz_state_t;

    // One shadow of a downstream pipeline register: enough to know whether
    // it will write a register, which one, and whether the value is a load.
    typedef struct packed {
        logic      valid;
        logic      is_load;
        reg_addr_t rd;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    function automatic logic uses_rs1(input opcode_t op);
        return (op == LOAD) || (op == STORE) || (op == ARITHMETIC_IMM) ||
               (op == ARITHMETIC_REG) || (op == BRANCH) || (op == JALR);
    endfunction

    function automatic logic uses_rs2(input opcode_t op);
        return (op == STORE) || (op == ARITHMETIC_REG) || (op == BRANCH);
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: compares one source register of the ID instruction against
// one shadow slot. Purely combinational; one instance per rs/slot pair.
module hazard_cmp
    import hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
)(
    input  logic [ADDR_W-1:0] rs,
    input  logic              rs_used,
    input  slot_t             slot,
    input  logic              slot_en,
    input  logic              load_only,
    output logic              hit
);

    logic [ADDR_W-1:0] slot_rd;

    assign slot_rd = ADDR_W'(slot.rd);

    // Flag a dependency only for a live, writing slot that the configuration cares about.
    always_comb begin
        hit = slot_en && rs_used && slot.valid &&
              (!load_only || slot.is_load) &&
              (slot_rd != '0) && (slot_rd != ADDR_W'(REG_UNKNOWN)) &&
              (rs == slot_rd);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller. Tracks shadow copies of the
// EX/MEM/WB destination registers and produces stall/flush controls for
// memory waits, taken redirects and read-after-write hazards.
// Optional feature macro: HAZARD_FORWARD_EN (forwarding present, so only a
// load sitting in EX can cause a one-cycle load-use stall).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid_i,
    input  opcode_t              id_op_i,
    input  reg_addr_t            id_rd_i,
    input  reg_addr_t            id_rs1_i,
    input  reg_addr_t            id_rs2_i,
    input  logic                 ex_redirect_i,
    input  logic                 dmem_req_i,
    input  logic                 dmem_ready_i,
    output logic                 pc_stall_o,
    output logic                 if_id_stall_o,
    output logic                 ex_mem_stall_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_flush_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o
);

    // Slot index 0 = EX, 1 = MEM, 2 = WB. Bit i of these masks configures slot i.
    // WB is never a hazard source because the register file writes through.
`ifdef HAZARD_FORWARD_EN
    localparam logic [2:0] SLOT_EN        = 3'b001;
    localparam logic [2:0] SLOT_LOAD_ONLY = 3'b001;
`else
    localparam logic [2:0] SLOT_EN        = 3'b011;
    localparam logic [2:0] SLOT_LOAD_ONLY = 3'b000;
`endif

    hz_state_t               state;
    hz_state_t               state_next;
    slot_t                   slots [3];
    slot_t                   id_slot;
    logic [5:0]              hits;
    logic [REG_ADDR_WIDTH-1:0] rs_sel [2];
    logic [1:0]              rs_used;
    logic                    mem_wait;
    logic                    raw_hazard;
    logic                    insert_bubble;

    assign mem_wait      = dmem_req_i && !dmem_ready_i;
    assign rs_sel[0]     = REG_ADDR_WIDTH'(id_rs1_i);
    assign rs_sel[1]     = REG_ADDR_WIDTH'(id_rs2_i);
    assign rs_used[0]    = uses_rs1(id_op_i);
    assign rs_used[1]    = uses_rs2(id_op_i);
    assign raw_hazard    = id_valid_i && (|hits);
    assign insert_bubble = ex_redirect_i || raw_hazard;

    assign id_slot.valid   = id_valid_i;
    assign id_slot.is_load = (id_op_i == LOAD);
    assign id_slot.rd      = id_rd_i;

    for (genvar s = 0; s < 3; s++) begin : g_slot
        for (genvar r = 0; r < 2; r++) begin : g_rs
            hazard_cmp #(
                .ADDR_W (REG_ADDR_WIDTH)
            ) u_cmp (
                .rs        (rs_sel[r]),
                .rs_used   (rs_used[r]),
                .slot      (slots[s]),
                .slot_en   (SLOT_EN[s]),
                .load_only (SLOT_LOAD_ONLY[s]),
                .hit       (hits[s*2+r])
            );
        end
    end

    // State register; reset drops any stall or wait in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state: memory wait dominates, a redirect clears any RAW stall.
    always_comb begin
        state_next = RUN;
        case (state)
            MEM_WAIT: begin
                state_next = mem_wait ? MEM_WAIT : RUN;
            end
            default: begin
                if (mem_wait) begin
                    state_next = MEM_WAIT;
                end else if (ex_redirect_i) begin
                    state_next = RUN;
                end else if (raw_hazard) begin
                    state_next = RAW_STALL;
                end else begin
                    state_next = RUN;
                end
            end
        endcase
    end

    // Stall/flush controls by priority wait > redirect > RAW; all quiet in reset.
    always_comb begin
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        if (rst_n) begin
            if (mem_wait) begin
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                ex_mem_stall_o = 1'b1;
            end else if (ex_redirect_i) begin
                if_id_flush_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
            end else if (raw_hazard) begin
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
            end
        end
    end

    // Shadow slots shift down the pipe unless the memory stage is waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots[0] <= SLOT_EMPTY;
            slots[1] <= SLOT_EMPTY;
            slots[2] <= SLOT_EMPTY;
        end else if (!mem_wait) begin
            slots[0] <= insert_bubble ? SLOT_EMPTY : id_slot;
            slots[1] <= slots[0];
            slots[2] <= slots[1];
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (pc_stall_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl. Runs a vector
// table, hand-written multi-cycle sequences and a randomized run against
// a history-based reference model. Follows HAZARD_FORWARD_EN if defined.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Output vector order: {pc_stall, if_id_stall, ex_mem_stall, if_id_flush, id_ex_flush}
    localparam logic [4:0] EXP_NONE  = 5'b00000;
    localparam logic [4:0] EXP_RAW   = 5'b11001;
    localparam logic [4:0] EXP_WAIT  = 5'b11100;
    localparam logic [4:0] EXP_REDIR = 5'b00011;

    typedef struct {
        logic      valid;
        opcode_t   op;
        reg_addr_t rd;
        reg_addr_t rs1;
        reg_addr_t rs2;
        logic      redirect;
        logic      req;
        logic      ready;
        logic [4:0] exp;
    } vec_t;

    typedef struct {
        logic      valid;
        logic      load;
        reg_addr_t rd;
    } hist_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    opcode_t     id_op;
    reg_addr_t   id_rd;
    reg_addr_t   id_rs1;
    reg_addr_t   id_rs2;
    logic        ex_redirect;
    logic        dmem_req;
    logic        dmem_ready;
    logic        pc_stall;
    logic        if_id_stall;
    logic        ex_mem_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic [31:0] stall_cnt;
    logic [4:0]  outs;

    int total = 0;
    int bad   = 0;

    vec_t  tbl [15];
    hist_t hist [$];

    assign outs = {pc_stall, if_id_stall, ex_mem_stall, if_id_flush, id_ex_flush};

    hazard_ctrl #(
        .REG_ADDR_WIDTH (5),
        .CNT_WIDTH      (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid_i     (id_valid),
        .id_op_i        (id_op),
        .id_rd_i        (id_rd),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .ex_redirect_i  (ex_redirect),
        .dmem_req_i     (dmem_req),
        .dmem_ready_i   (dmem_ready),
        .pc_stall_o     (pc_stall),
        .if_id_stall_o  (if_id_stall),
        .ex_mem_stall_o (ex_mem_stall),
        .if_id_flush_o  (if_id_flush),
        .id_ex_flush_o  (id_ex_flush),
        .stall_cnt_o    (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input opcode_t op, input int rd, input int rs1,
                                input int rs2, input logic redir, input logic req,
                                input logic ready, input logic [4:0] exp);
        vec_t t;
        t.valid = v; t.op = op;
        t.rd = reg_addr_t'(rd); t.rs1 = reg_addr_t'(rs1); t.rs2 = reg_addr_t'(rs2);
        t.redirect = redir; t.req = req; t.ready = ready; t.exp = exp;
        return t;
    endfunction

    // Operand usage and register writing, written from the opcode definitions.
    function automatic logic readsRs1(input opcode_t op);
        case (op)
            LOAD, STORE, ARITHMETIC_IMM, ARITHMETIC_REG, BRANCH, JALR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic readsRs2(input opcode_t op);
        case (op)
            STORE, ARITHMETIC_REG, BRANCH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic writesRd(input opcode_t op);
        case (op)
            LUI, AUIPC, JAL, JALR, LOAD, ARITHMETIC_IMM, ARITHMETIC_REG: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic applyStimulus(input logic v, input opcode_t op, input int rd, input int rs1,
                                 input int rs2, input logic redir, input logic req,
                                 input logic ready);
        id_valid    = v;
        id_op       = op;
        id_rd       = reg_addr_t'(rd);
        id_rs1      = reg_addr_t'(rs1);
        id_rs2      = reg_addr_t'(rs2);
        ex_redirect = redir;
        dmem_req    = req;
        dmem_ready  = ready;
    endtask

    task automatic checkOutput(input string name, input logic [4:0] exp);
        total++;
        if (outs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: outputs=%b expected=%b", name, outs, exp);
        end
    endtask

    task automatic checkCount(input string name, input logic [31:0] exp);
        total++;
        if (stall_cnt !== exp) begin
            bad++;
            $display("[TB] FAIL %s: stall_cnt=%0d expected=%0d", name, stall_cnt, exp);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, ARITHMETIC_IMM, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic runStep(input string name, input logic [4:0] exp);
        @(negedge clk);
        checkOutput(name, exp);
        nextCycle();
    endtask

    task automatic doReset();
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int expStalls;
        int cntModel;
        int window;
        logic [4:0] exp;
        logic hz;
        logic mw;
        hist_t e;

        $display("[TB] start, forwarding=%0d", FWD);

        // Reset: outputs quiet even with wait and redirect requested.
        rst_n = 1'b0;
        applyStimulus(1'b1, ARITHMETIC_REG, 6, 5, 1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("reset_outputs", EXP_NONE);
        checkCount("reset_count", 0);
        @(posedge clk);
        #1;
        idle();
        rst_n = 1'b1;

        // Vector table; expectations hold with or without forwarding.
        tbl[0]  = mk(1, LOAD,           12, 1, 0,  0, 0, 0, EXP_NONE);
        tbl[0].rd = reg_addr_t'(5);
        tbl[1]  = mk(1, ARITHMETIC_REG, 6,  5, 1,  0, 0, 0, EXP_RAW);
        tbl[2]  = mk(1, ARITHMETIC_REG, 6,  5, 1,  1, 0, 0, EXP_REDIR);
        tbl[3]  = mk(0, ARITHMETIC_IMM, 0,  0, 0,  0, 1, 0, EXP_WAIT);
        tbl[4]  = mk(0, ARITHMETIC_IMM, 0,  0, 0,  0, 1, 1, EXP_NONE);
        tbl[5]  = mk(1, ARITHMETIC_IMM, 0,  2, 0,  0, 0, 0, EXP_NONE);
        tbl[6]  = mk(1, ARITHMETIC_REG, 3,  0, 0,  0, 0, 0, EXP_NONE);
        tbl[7]  = mk(1, LUI,            7,  3, 3,  0, 0, 0, EXP_NONE);
        tbl[8]  = mk(1, ARITHMETIC_IMM, 8,  9, 7,  0, 0, 0, EXP_NONE);
        tbl[9]  = mk(0, ARITHMETIC_REG, 9,  8, 8,  0, 0, 0, EXP_NONE);
        tbl[10] = mk(1, LOAD,           12, 1, 0,  0, 0, 0, EXP_NONE);
        tbl[11] = mk(1, STORE,          0,  2, 12, 0, 0, 0, EXP_RAW);
        tbl[12] = mk(1, STORE,          0,  2, 12, 1, 1, 0, EXP_WAIT);
        tbl[13] = mk(1, STORE,          0,  2, 12, 1, 0, 0, EXP_REDIR);
        tbl[14] = mk(0, ARITHMETIC_IMM, 0,  0, 0,  0, 0, 0, EXP_NONE);
        expStalls = 0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i].valid, tbl[i].op, int'(tbl[i].rd), int'(tbl[i].rs1),
                          int'(tbl[i].rs2), tbl[i].redirect, tbl[i].req, tbl[i].ready);
            if (tbl[i].exp[4]) expStalls++;
            runStep($sformatf("table_row%0d", i), tbl[i].exp);
        end
        idle();
        @(negedge clk);
        checkCount("table_stall_count", 32'(expStalls));
        nextCycle();

        // Load-use / ALU-use sequences, depending on forwarding.
        doReset();
        applyStimulus(1, LOAD, 5, 1, 0, 0, 0, 0);
        runStep("load_use_load", EXP_NONE);
        applyStimulus(1, ARITHMETIC_REG, 6, 5, 1, 0, 0, 0);
        runStep("load_use_c1", EXP_RAW);
        runStep("load_use_c2", FWD ? EXP_NONE : EXP_RAW);
        runStep("load_use_c3", EXP_NONE);
        idle();
        @(negedge clk);
        checkCount("load_use_count", FWD ? 32'd1 : 32'd2);
        nextCycle();

        doReset();
        applyStimulus(1, ARITHMETIC_IMM, 5, 1, 0, 0, 0, 0);
        runStep("alu_use_addi", EXP_NONE);
        applyStimulus(1, ARITHMETIC_REG, 7, 5, 5, 0, 0, 0);
        runStep("alu_use_c1", FWD ? EXP_NONE : EXP_RAW);
        runStep("alu_use_c2", FWD ? EXP_NONE : EXP_RAW);
        runStep("alu_use_c3", EXP_NONE);
        idle();
        @(negedge clk);
        checkCount("alu_use_count", FWD ? 32'd0 : 32'd2);
        nextCycle();

        // Redirect overrides a RAW hazard without stalling.
        doReset();
        applyStimulus(1, LOAD, 5, 1, 0, 0, 0, 0);
        runStep("redir_load", EXP_NONE);
        applyStimulus(1, ARITHMETIC_REG, 6, 5, 1, 1, 0, 0);
        runStep("redir_raw", EXP_REDIR);
        idle();
        @(negedge clk);
        checkOutput("redir_after", EXP_NONE);
        checkCount("redir_count", 0);
        nextCycle();

        // Three wait cycles freeze the slots; the load stays in EX afterwards.
        doReset();
        applyStimulus(1, LOAD, 5, 1, 0, 0, 0, 0);
        runStep("wait_load", EXP_NONE);
        applyStimulus(0, ARITHMETIC_IMM, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) runStep($sformatf("wait_c%0d", i), EXP_WAIT);
        applyStimulus(1, ARITHMETIC_REG, 6, 5, 1, 0, 0, 0);
        @(negedge clk);
        checkCount("wait_count", 3);
        checkOutput("wait_frozen_ex", EXP_RAW);
        nextCycle();

        // Asynchronous reset in the middle of a wait.
        doReset();
        applyStimulus(1, LOAD, 5, 1, 0, 0, 0, 0);
        runStep("rstwait_load", EXP_NONE);
        applyStimulus(0, ARITHMETIC_IMM, 0, 0, 0, 0, 1, 0);
        runStep("rstwait_c0", EXP_WAIT);
        @(negedge clk);
        checkOutput("rstwait_c1", EXP_WAIT);
        checkCount("rstwait_count_before", 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstwait_async_out", EXP_NONE);
        checkCount("rstwait_async_count", 0);
        @(posedge clk);
        #1;
        applyStimulus(1, ARITHMETIC_REG, 6, 5, 1, 0, 0, 0);
        rst_n = 1'b1;
        runStep("rstwait_after_release", EXP_NONE);

        // Randomized run against a history model of issued instructions.
        doReset();
        hist.delete();
        e.valid = 1'b0; e.load = 1'b0; e.rd = '0;
        for (int i = 0; i < 3; i++) hist.push_back(e);
        cntModel = 0;
        window = FWD ? 1 : 2;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            opcode_t op;
            op = opcode_t'(4'($urandom_range(0, 9)));
            applyStimulus(($urandom_range(0, 3) != 0), op,
                          writesRd(op) ? int'($urandom_range(0, 3)) : int'(REG_UNKNOWN),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)));
            hz = 1'b0;
            for (int d = 0; d < window; d++) begin
                if (hist[d].valid && hist[d].rd != 0 && (!FWD || hist[d].load)) begin
                    if (readsRs1(id_op) && id_rs1 == hist[d].rd) hz = 1'b1;
                    if (readsRs2(id_op) && id_rs2 == hist[d].rd) hz = 1'b1;
                end
            end
            mw = dmem_req && !dmem_ready;
            if (mw)                   exp = EXP_WAIT;
            else if (ex_redirect)     exp = EXP_REDIR;
            else if (id_valid && hz)  exp = EXP_RAW;
            else                      exp = EXP_NONE;
            @(negedge clk);
            checkOutput($sformatf("rand_out_%0d", cyc), exp);
            checkCount($sformatf("rand_cnt_%0d", cyc), 32'(cntModel));
            if (exp[4]) cntModel++;
            if (!mw) begin
                if (ex_redirect || (id_valid && hz)) begin
                    e.valid = 1'b0; e.load = 1'b0; e.rd = '0;
                end else begin
                    e.valid = id_valid; e.load = (id_op == LOAD); e.rd = id_rd;
                end
                hist.push_front(e);
                void'(hist.pop_back());
            end
            nextCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
